// File: rtl/ram_sweep_clr.sv
// Single-clock RAM with one write port, one read port and selectable read latency.
// Clearing walks the array one word per cycle while busy is high, so it maps to block RAM.
module ram_sweep_clr #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 16,
  parameter int READ_LAT = 0,
  parameter int RW_MODE  = 0
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     clr_req,
  input  logic                     wen,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     ren,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic                     busy
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nx;
  logic [AW-1:0]     ptr, ptr_nx;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              waddr_ok, raddr_ok;
  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [WIDTH-1:0]  mem_wd;
  logic [AW-1:0]     raddr_idx;
  logic [WIDTH-1:0]  mem_rd;

  // Handshake: a read is accepted when ren is high and busy is low; rvalid marks
  // the cycle its data is on rdata (same cycle for READ_LAT=0, next for READ_LAT=1).
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      CLEAR: begin
        if (ptr == LAST) begin
          state_nx = IDLE;
          ptr_nx   = '0;
        end else begin
          ptr_nx = ptr + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        ptr_nx   = '0;
      end
    endcase
  end

  assign busy     = (state == CLEAR);
  assign waddr_ok = ({1'b0, waddr} < DEPTH_W);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_W);

  // One physical write port shared by reset, the sweep and user writes.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (clr) begin
      mem_we = 1'b1;
    end else if (busy) begin
      mem_we = 1'b1;
      mem_wa = ptr;
    end else if (wen && waddr_ok) begin
      mem_we = 1'b1;
      mem_wa = waddr;
      mem_wd = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign raddr_idx = raddr_ok ? raddr : '0;
  assign mem_rd    = mem[raddr_idx];

  generate
    if (READ_LAT == 0) begin : g_comb_read
      assign rdata  = (!busy && raddr_ok) ? mem_rd : '0;
      assign rvalid = ren && !busy;
    end else begin : g_reg_read
      logic [WIDTH-1:0] rdata_q;
      logic             rvalid_q;
      logic             collide;

      assign collide = (RW_MODE == 1) && wen && (waddr == raddr);

      always_ff @(posedge clk) begin
        if (clr) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else if (ren && !busy) begin
          rvalid_q <= 1'b1;
          if (!raddr_ok)    rdata_q <= '0;
          else if (collide) rdata_q <= wdata;
          else              rdata_q <= mem_rd;
        end else begin
          rvalid_q <= 1'b0;
        end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sweep_clr.sv
// Directed bench for ram_sweep_clr: three instances share stimulus
// (16x8 read-first, 16x8 write-first, 12x8 combinational read).
module tb_ram_sweep_clr;

  logic       clk = 1'b0;
  logic       clr, clr_req, wen, ren;
  logic [3:0] waddr, raddr;
  logic [7:0] wdata;

  logic [7:0] rdata0, rdata1, rdata2;
  logic       rvalid0, rvalid1, rvalid2;
  logic       busy0, busy1, busy2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_sweep_clr #(.WIDTH(8), .DEPTH(16), .READ_LAT(1), .RW_MODE(0)) u_rf (
    .clk(clk), .clr(clr), .clr_req(clr_req), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0));

  ram_sweep_clr #(.WIDTH(8), .DEPTH(16), .READ_LAT(1), .RW_MODE(1)) u_wf (
    .clk(clk), .clr(clr), .clr_req(clr_req), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1));

  ram_sweep_clr #(.WIDTH(8), .DEPTH(12), .READ_LAT(0), .RW_MODE(0)) u_d12 (
    .clk(clk), .clr(clr), .clr_req(clr_req), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata2), .rvalid(rvalid2), .busy(busy2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    clr = 1'b1; clr_req = 1'b0; wen = 1'b0; ren = 1'b0;
    waddr = '0; raddr = '0; wdata = '0;

    // Reset edge
    tick();
    chk("rst_rdata0", rdata0, 8'h00);
    chk("rst_rvalid0", {7'd0, rvalid0}, 8'h00);
    chk("rst_rdata1", rdata1, 8'h00);
    chk("rst_busy1", {7'd0, busy1}, 8'h01);
    clr = 1'b0;

    // T1: busy for exactly DEPTH cycles after the reset edge
    for (int i = 0; i < 20; i++) begin
      chk("t1_busy16", {7'd0, busy0}, (i < 16) ? 8'h01 : 8'h00);
      chk("t1_busy12", {7'd0, busy2}, (i < 12) ? 8'h01 : 8'h00);
      tick();
    end

    // T1: every word reads back zero
    for (int a = 0; a < 16; a++) begin
      raddr = 4'(a);
      ren   = 1'b1;
      #1;
      chk("t1_rd12_data", rdata2, 8'h00);
      chk("t1_rd12_vld", {7'd0, rvalid2}, 8'h01);
      tick();
      chk("t1_rd16_vld", {7'd0, rvalid0}, 8'h01);
      chk("t1_rd16_data", rdata0, 8'h00);
    end
    ren = 1'b0;
    tick();
    chk("t1_idle_vld", {7'd0, rvalid0}, 8'h00);
    chk("t1_idle_hold", rdata0, 8'h00);

    // T2: write 0xA5@3 and 0x5A@15, read them back
    wen = 1'b1; waddr = 4'd3; wdata = 8'hA5;
    tick();
    waddr = 4'd15; wdata = 8'h5A;
    tick();
    wen = 1'b0;
    ren = 1'b1; raddr = 4'd3;
    #1;
    chk("t2_pre_vld", {7'd0, rvalid0}, 8'h00);
    chk("t2_comb_a5", rdata2, 8'hA5);
    tick();
    chk("t2_vld", {7'd0, rvalid0}, 8'h01);
    chk("t2_a5_rf", rdata0, 8'hA5);
    chk("t2_a5_wf", rdata1, 8'hA5);
    raddr = 4'd15;
    #1;
    chk("t2_d12_oob", rdata2, 8'h00);
    chk("t2_d12_oob_vld", {7'd0, rvalid2}, 8'h01);
    tick();
    chk("t2_5a_rf", rdata0, 8'h5A);
    ren = 1'b0;

    // T3: same-address read/write collision
    wen = 1'b1; waddr = 4'd7; wdata = 8'h11;
    tick();
    wdata = 8'h22; ren = 1'b1; raddr = 4'd7;
    #1;
    chk("t3_comb_old", rdata2, 8'h11);
    tick();
    chk("t3_read_first", rdata0, 8'h11);
    chk("t3_write_first", rdata1, 8'h22);
    wen = 1'b0;
    #1;
    chk("t3_comb_new", rdata2, 8'h22);
    tick();
    chk("t3_after_rf", rdata0, 8'h22);
    chk("t3_after_wf", rdata1, 8'h22);
    ren = 1'b0;

    // T4: write/read during a clr_req sweep are refused
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("t4_busy_on", {7'd0, busy0}, 8'h01);
    repeat (4) tick();
    wen = 1'b1; waddr = 4'd2; wdata = 8'hFF; ren = 1'b1; raddr = 4'd2;
    #1;
    chk("t4_comb_vld", {7'd0, rvalid2}, 8'h00);
    chk("t4_comb_data", rdata2, 8'h00);
    tick();
    chk("t4_vld_rf", {7'd0, rvalid0}, 8'h00);
    chk("t4_hold_rf", rdata0, 8'h22);
    chk("t4_hold_wf", rdata1, 8'h22);
    wen = 1'b0; ren = 1'b0;
    repeat (10) tick();
    chk("t4_busy_last", {7'd0, busy0}, 8'h01);
    tick();
    chk("t4_busy_off", {7'd0, busy0}, 8'h00);
    ren = 1'b1; raddr = 4'd2;
    tick();
    chk("t4_rd2", rdata0, 8'h00);
    chk("t4_rd2_vld", {7'd0, rvalid0}, 8'h01);
    raddr = 4'd3;
    tick();
    chk("t4_rd3_swept", rdata0, 8'h00);
    ren = 1'b0;

    // T5a: clr_req during a sweep is ignored
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 18; i++) begin
      chk("t5_req_busy16", {7'd0, busy0}, (i < 16) ? 8'h01 : 8'h00);
      chk("t5_req_busy12", {7'd0, busy2}, (i < 12) ? 8'h01 : 8'h00);
      clr_req = (i == 2);
      tick();
    end
    clr_req = 1'b0;

    // T5b: clr mid-sweep restarts it
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 27; i++) begin
      chk("t5_clr_busy16", {7'd0, busy0}, (i < 24) ? 8'h01 : 8'h00);
      chk("t5_clr_busy12", {7'd0, busy2}, (i < 20) ? 8'h01 : 8'h00);
      clr = (i == 7);
      tick();
    end
    clr = 1'b0;
    chk("t5_clr_rdata", rdata0, 8'h00);

    // T6: out-of-range address on the 12-deep instance
    wen = 1'b1; waddr = 4'd11; wdata = 8'h3C;
    tick();
    waddr = 4'd13; wdata = 8'h07;
    tick();
    wen = 1'b0;
    ren = 1'b1; raddr = 4'd13;
    #1;
    chk("t6_oob_data", rdata2, 8'h00);
    chk("t6_oob_vld", {7'd0, rvalid2}, 8'h01);
    tick();
    chk("t6_d16_13", rdata0, 8'h07);
    raddr = 4'd11;
    #1;
    chk("t6_last_word", rdata2, 8'h3C);
    tick();
    chk("t6_d16_11", rdata0, 8'h3C);
    ren = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
